// File: rtl/ltssm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ltssm_pkg
//  Description : Shared LTSSM definitions. Holds the 4-bit substate encoding
//                used between mainLTSSM and its Rx substate helpers, and the
//                state type of the Rx polling FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
package ltssm_pkg;

    // Shared 4-bit substate encoding
    localparam logic [3:0] detectQuiet                  = 4'd0;
    localparam logic [3:0] detectActive                 = 4'd1;
    localparam logic [3:0] pollingActive                = 4'd2;
    localparam logic [3:0] pollingConfiguration         = 4'd3;
    localparam logic [3:0] configurationLinkWidthStart  = 4'd4;
    localparam logic [3:0] configurationLinkWidthAccept = 4'd5;
    localparam logic [3:0] configurationLanenumWait     = 4'd6;
    localparam logic [3:0] configurationLanenumAccept   = 4'd7;
    localparam logic [3:0] configurationComplete        = 4'd8;
    localparam logic [3:0] configurationIdle            = 4'd9;
    localparam logic [3:0] L0                           = 4'd10;

    // Rx polling FSM states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        QUIET  = 3'd1,
        ACTIVE = 3'd2,
        CONFIG = 3'd3,
        DONE   = 3'd4
    } rxState_t;

    // Working state that a given Rx substate selects
    function automatic rxState_t entryState(input logic [3:0] sub);
        rxState_t result;
        case (sub)
            detectQuiet:          result = QUIET;
            pollingActive:        result = ACTIVE;
            pollingConfiguration: result = CONFIG;
            default:              result = IDLE;
        endcase
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ltssm_timer.sv
`default_nettype none
// ============================================================================
//  Module      : ltssm_timer
//  Description : Loadable saturating up-counter with synchronous clear, load
//                and enable, plus an equality compare against a terminal
//                value supplied by the owner.
//  Revision    : 1.0 - initial release
// ============================================================================
module ltssm_timer #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] loadValue,
    input  logic             enable,
    input  logic [WIDTH-1:0] terminal,
    output logic             atTerminal
);

    logic [WIDTH-1:0] r_count;

    // Count register: clear beats load beats increment; holds at all-ones
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= loadValue;
        end else if (enable && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign atTerminal = (r_count == terminal);

endmodule
`default_nettype wire

// File: rtl/ltssm_rx_polling.sv
`default_nettype none
// ============================================================================
//  Module      : ltssm_rx_polling
//  Description : Rx-side substate helper for Detect.Quiet, Polling.Active and
//                Polling.Configuration. Counts consecutive qualifying ordered
//                sets (or dwells in Detect.Quiet) and raises finishRx with the
//                substate mainLTSSM should move to.
//                Optional feature macro: LTSSM_RX_TIMEOUT_EN enables the
//                Polling substate timeout back to Detect.Quiet.
//  Revision    : 1.0 - initial release
// ============================================================================
module ltssm_rx_polling
    import ltssm_pkg::*;
#(
    parameter int TS_COUNT       = 8,
    parameter int QUIET_CYCLES   = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] substateRx,
    input  logic       tsValid,
    input  logic       tsType,
    input  logic       tsLinkPad,
    input  logic       tsLanePad,
    output logic       finishRx,
    output logic [3:0] gotoRx
);

    localparam int CNT_W      = $clog2(TS_COUNT + 1);
    localparam int TIMER_SPAN = (QUIET_CYCLES > TIMEOUT_CYCLES) ? QUIET_CYCLES : TIMEOUT_CYCLES;
    localparam int TIMER_W    = (TIMER_SPAN > 1) ? $clog2(TIMER_SPAN) : 1;

    localparam logic [CNT_W-1:0]   c_countFull   = CNT_W'(TS_COUNT);
    localparam logic [CNT_W-1:0]   c_countLast   = CNT_W'(TS_COUNT - 1);
    localparam logic [TIMER_W-1:0] c_quietLast   = TIMER_W'(QUIET_CYCLES - 1);
    localparam logic [TIMER_W-1:0] c_timeoutLast = TIMER_W'(TIMEOUT_CYCLES - 1);

    rxState_t         r_state;
    rxState_t         w_nextState;
    rxState_t         w_entry;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_nextCount;
    logic [3:0]       r_gotoRx;
    logic [3:0]       w_nextGoto;
    logic [3:0]       r_doneSub;
    logic [3:0]       w_nextDoneSub;
    logic             w_timerClear;
    logic             w_timerEn;
    logic             w_timerHit;
    logic [TIMER_W-1:0] w_timerTerminal;
    logic             w_qualifying;
    logic             w_complete;
    logic             w_done;

    assign w_entry         = entryState(substateRx);
    assign w_timerTerminal = (r_state == QUIET) ? c_quietLast : c_timeoutLast;

    ltssm_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .clear      (w_timerClear),
        .load       (1'b0),
        .loadValue  ({TIMER_W{1'b0}}),
        .enable     (w_timerEn),
        .terminal   (w_timerTerminal),
        .atTerminal (w_timerHit)
    );

    // State, ordered-set counter, latched target and DONE-entry substate
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_gotoRx  <= '0;
            r_doneSub <= '0;
        end else begin
            r_state   <= w_nextState;
            r_count   <= w_nextCount;
            r_gotoRx  <= w_nextGoto;
            r_doneSub <= w_nextDoneSub;
        end
    end

    // Next-state: substate entry first, then per-state progress toward DONE
    always_comb begin
        w_nextState   = r_state;
        w_nextCount   = r_count;
        w_nextGoto    = r_gotoRx;
        w_nextDoneSub = r_doneSub;
        w_timerClear  = 1'b0;
        w_timerEn     = 1'b0;
        w_qualifying  = 1'b0;
        w_complete    = 1'b0;

        if (r_state == DONE) begin
            // Hold the request until mainLTSSM moves off the substate
            if (substateRx != r_doneSub) begin
                w_nextState  = w_entry;
                w_nextCount  = '0;
                w_timerClear = 1'b1;
            end
        end else if (w_entry != r_state) begin
            // Substate changed: abandon any partial progress
            w_nextState  = w_entry;
            w_nextCount  = '0;
            w_timerClear = 1'b1;
        end else begin
            case (r_state)
                QUIET: begin
                    w_timerEn = 1'b1;
                    if (w_timerHit) begin
                        w_nextState   = DONE;
                        w_nextGoto    = detectActive;
                        w_nextDoneSub = substateRx;
                    end
                end
                ACTIVE, CONFIG: begin
                    // Configuration only accepts TS2; Active accepts either type
                    w_qualifying = tsValid && tsLinkPad && tsLanePad &&
                                   (tsType || (r_state == ACTIVE));
                    w_complete   = w_qualifying && (r_count == c_countLast);
                    if (w_qualifying) begin
                        if (r_count != c_countFull) begin
                            w_nextCount = r_count + CNT_W'(1);
                        end
                    end else if (tsValid) begin
                        w_nextCount = '0;
                    end
                    if (w_complete) begin
                        w_nextState   = DONE;
                        w_nextGoto    = (r_state == ACTIVE) ? pollingConfiguration
                                                            : configurationLinkWidthStart;
                        w_nextDoneSub = substateRx;
                    end
`ifdef LTSSM_RX_TIMEOUT_EN
                    // Timeout loses to a completion landing on the same cycle
                    w_timerEn = 1'b1;
                    if (!w_complete && w_timerHit) begin
                        w_nextState   = DONE;
                        w_nextGoto    = detectQuiet;
                        w_nextDoneSub = substateRx;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    assign w_done   = (r_state == DONE);
    assign finishRx = w_done;
    assign gotoRx   = w_done ? r_gotoRx : 4'd0;

endmodule
`default_nettype wire

// File: tb/tb_ltssm_rx_polling.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ltssm_rx_polling
//  Description : Self-checking bench for ltssm_rx_polling. Stimulus pushes the
//                expected (cycle, gotoRx) of each exit request into a queue;
//                a monitor pops and compares on every finishRx rise.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ltssm_rx_polling;
    import ltssm_pkg::*;

    localparam int TS_COUNT       = 8;
    localparam int QUIET_CYCLES   = 16;
    localparam int TIMEOUT_CYCLES = 1024;
    localparam logic [3:0] c_idleSub = 4'd15;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] substateRx;
    logic       tsValid;
    logic       tsType;
    logic       tsLinkPad;
    logic       tsLanePad;
    logic       finishRx;
    logic [3:0] gotoRx;

    ltssm_rx_polling #(
        .TS_COUNT       (TS_COUNT),
        .QUIET_CYCLES   (QUIET_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .substateRx (substateRx),
        .tsValid    (tsValid),
        .tsType     (tsType),
        .tsLinkPad  (tsLinkPad),
        .tsLanePad  (tsLanePad),
        .finishRx   (finishRx),
        .gotoRx     (gotoRx)
    );

    initial forever #5 clk = ~clk;

    typedef struct { int cyc; logic [3:0] goto; } exp_t;
    typedef struct { bit typ; bit link; bit lane; } ts_t;

    exp_t       expQ[$];
    ts_t        lst[$];
    int         cyc    = 0;
    int         checks = 0;
    int         errors = 0;
    bit         prevFinish = 1'b0;
    logic [3:0] held = 4'd0;
    exp_t       e;
    int         entryCyc;

    // Cycle index: value after each rising edge
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Reference: index of the set completing the run of TS_COUNT, or -1
    function automatic int completeIdx(input bit isCfg, input ts_t l[$]);
        int run = 0;
        foreach (l[i]) begin
            if (l[i].link && l[i].lane && (!isCfg || l[i].typ)) begin
                run++;
                if (run == TS_COUNT) return i;
            end else begin
                run = 0;
            end
        end
        return -1;
    endfunction

    // Monitor: every finishRx rise must match the oldest expectation
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            prevFinish = 1'b0;
        end else begin
            if (finishRx && !prevFinish) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected finishRx: got request gotoRx=%0d at cycle %0d, required none", gotoRx, cyc);
                end else begin
                    e = expQ.pop_front();
                    check("finishRx cycle", cyc, e.cyc);
                    check("gotoRx", int'(gotoRx), int'(e.goto));
                end
                held = gotoRx;
            end else if (finishRx) begin
                check("gotoRx hold", int'(gotoRx), int'(held));
            end
            prevFinish = finishRx;
        end
    end

    task automatic drive(input logic [3:0] sub, input bit v, input bit t, input bit l, input bit n);
        @(posedge clk);
        #1;
        substateRx = sub;
        tsValid    = v;
        tsType     = t;
        tsLinkPad  = l;
        tsLanePad  = n;
    endtask

    task automatic goIdle();
        drive(c_idleSub, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        check("finishRx after exit", int'(finishRx), 0);
        check("gotoRx in IDLE", int'(gotoRx), 0);
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while (expQ.size() != 0 && n < bound) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d request(s) pending, next due cycle %0d, required 0 pending", expQ.size(), expQ[0].cyc);
            expQ.delete();
        end
    endtask

    task automatic addTs(input bit t, input bit l, input bit n);
        lst.push_back('{t, l, n});
    endtask

    task automatic runTs(input logic [3:0] sub, input ts_t l[$], input bit fresh);
        bit isCfg = (sub == pollingConfiguration);
        int k;
        int entry;
        if (fresh) goIdle();
        k = completeIdx(isCfg, l);
        drive(sub, 0, 0, 0, 0);
        entry = cyc + 1;
        foreach (l[i]) begin
            repeat ($urandom_range(0, 3)) drive(sub, 0, 0, 0, 0);
            drive(sub, 1, l[i].typ, l[i].link, l[i].lane);
            if (i == k)
                expQ.push_back('{cyc + 1, (isCfg ? configurationLinkWidthStart : pollingConfiguration)});
        end
        drive(sub, 0, 0, 0, 0);
`ifdef LTSSM_RX_TIMEOUT_EN
        if (k < 0) expQ.push_back('{entry + TIMEOUT_CYCLES, detectQuiet});
`else
        if (entry < 0) $display("entry cycle negative");
`endif
        drain(TIMEOUT_CYCLES + 64);
        repeat (3) drive(sub, 0, 0, 0, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; substateRx = c_idleSub;
        tsValid = 0; tsType = 0; tsLinkPad = 0; tsLanePad = 0;
        repeat (3) @(negedge clk);
        check("reset finishRx", int'(finishRx), 0);
        check("reset gotoRx", int'(gotoRx), 0);
        @(posedge clk); #1 reset = 1'b1;

        // Quiet dwell, then hold in DONE for a few cycles
        goIdle();
        drive(detectQuiet, 0, 0, 0, 0);
        expQ.push_back('{cyc + 1 + QUIET_CYCLES, detectActive});
        drain(64);
        repeat (4) drive(detectQuiet, 0, 0, 0, 0);

        // Active pass: 8 TS1 PAD/PAD
        lst.delete();
        repeat (TS_COUNT) addTs(0, 1, 1);
        runTs(pollingActive, lst, 1);

        // Config break: 5 TS2, 1 TS1, 8 TS2
        lst.delete();
        repeat (5) addTs(1, 1, 1);
        addTs(0, 1, 1);
        repeat (8) addTs(1, 1, 1);
        runTs(pollingConfiguration, lst, 1);

        // Interrupt: 4 sets in Active, then Configuration needs a full 8
        goIdle();
        drive(pollingActive, 0, 0, 0, 0);
        repeat (4) begin
            drive(pollingActive, 0, 0, 0, 0);
            drive(pollingActive, 1, 0, 1, 1);
        end
        lst.delete();
        repeat (TS_COUNT) addTs(1, 1, 1);
        runTs(pollingConfiguration, lst, 0);

        // Randomized ordered-set streams
        for (int s = 0; s < 10; s++) begin
            bit cfg = (s % 2) == 1;
            lst.delete();
            for (int i = 0; i < 14; i++)
                addTs(cfg ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 1) == 1),
                      $urandom_range(0, 9) != 0, $urandom_range(0, 9) != 0);
            runTs(cfg ? pollingConfiguration : pollingActive, lst, 1);
        end

`ifdef LTSSM_RX_TIMEOUT_EN
        // Timeout with no ordered sets
        goIdle();
        drive(pollingActive, 0, 0, 0, 0);
        expQ.push_back('{cyc + 1 + TIMEOUT_CYCLES, detectQuiet});
        drain(TIMEOUT_CYCLES + 64);

        // Race: 8th set lands on the timeout cycle
        goIdle();
        drive(pollingActive, 0, 0, 0, 0);
        entryCyc = cyc + 1;
        repeat (TS_COUNT - 1) begin
            drive(pollingActive, 1, 0, 1, 1);
            drive(pollingActive, 0, 0, 0, 0);
        end
        while (cyc < entryCyc + TIMEOUT_CYCLES - 2) drive(pollingActive, 0, 0, 0, 0);
        drive(pollingActive, 1, 1, 1, 1);
        expQ.push_back('{cyc + 1, pollingConfiguration});
        drain(64);
`else
        // No timeout: Active waits indefinitely
        goIdle();
        drive(pollingActive, 0, 0, 0, 0);
        entryCyc = cyc;
        while (cyc < entryCyc + 5000) drive(pollingActive, 0, 0, 0, 0);
        @(negedge clk);
        check("no timeout finishRx", int'(finishRx), 0);
`endif

        // Reset mid-DONE drops the request immediately
        goIdle();
        drive(detectQuiet, 0, 0, 0, 0);
        expQ.push_back('{cyc + 1 + QUIET_CYCLES, detectActive});
        drain(64);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("reset mid-DONE finishRx", int'(finishRx), 0);
        check("reset mid-DONE gotoRx", int'(gotoRx), 0);
        @(posedge clk); #1 reset = 1'b1;
        expQ.push_back('{cyc + 1 + QUIET_CYCLES, detectActive});
        drain(64);
        goIdle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
